// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a one-entry valid/ready output stage.
// Optional automatic code sweep is compiled in with DECODER_SEQ_SCAN_EN.
module decoder_seq #(
  parameter int IN_W       = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_code,
  input  logic                   enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1<<IN_W)-1:0]   d,
  output logic [IN_W-1:0]        out_code
`ifdef DECODER_SEQ_SCAN_EN
  ,
  input  logic                   scan_start,
  output logic                   scan_busy
`endif
);

  localparam int OUT_W = 1 << IN_W;
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};
  localparam logic [IN_W-1:0]  MAX_CODE = {IN_W{1'b1}};

  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code, input logic en);
    logic [OUT_W-1:0] hot;
    hot = en ? (OUT_W'(1) << code) : '0;
    return ACTIVE_LOW ? ~hot : hot;
  endfunction

  logic slot_free;
  logic complete;
  logic accept;

  assign slot_free = !out_valid || out_ready;
  assign complete  = out_valid && out_ready;
  assign accept    = in_valid && in_ready;

`ifdef DECODER_SEQ_SCAN_EN
  typedef enum logic {IDLE, SCAN} state_t;

  state_t          state;
  logic [IN_W-1:0] cnt;
  logic [IN_W-1:0] cnt_next;
  logic            scan_go;

  assign cnt_next  = cnt + IN_W'(1);
  // A sweep may only start once the output slot is free; it then owns the port.
  assign scan_go   = (state == IDLE) && scan_start && slot_free;
  assign in_ready  = (state == IDLE) && slot_free && !scan_start;
  assign scan_busy = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      d         <= INACTIVE;
      out_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_go) begin
            state     <= SCAN;
            cnt       <= '0;
            out_valid <= 1'b1;
            d         <= decode('0, 1'b1);
            out_code  <= '0;
          end else if (accept) begin
            out_valid <= 1'b1;
            d         <= decode(in_code, enable);
            out_code  <= in_code;
          end else if (complete) begin
            out_valid <= 1'b0;
          end
        end
        SCAN: begin
          // cnt always names the code currently held in the output register.
          if (complete) begin
            if (cnt == MAX_CODE) begin
              state     <= IDLE;
              cnt       <= '0;
              out_valid <= 1'b0;
            end else begin
              cnt       <= cnt_next;
              out_valid <= 1'b1;
              d         <= decode(cnt_next, 1'b1);
              out_code  <= cnt_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= INACTIVE;
      out_code  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      d         <= decode(in_code, enable);
      out_code  <= in_code;
    end else if (complete) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq (IN_W=3, ACTIVE_LOW=0) with a beat scoreboard.
module tb_decoder_seq;

  localparam int IN_W  = 3;
  localparam int OUT_W = 1 << IN_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             enable;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] d;
  logic [IN_W-1:0]  out_code;
`ifdef DECODER_SEQ_SCAN_EN
  logic             scan_start;
  logic             scan_busy;
`endif

  int tests = 0;
  int fails = 0;
  logic [IN_W+OUT_W-1:0] sb[$];

  decoder_seq #(.IN_W(IN_W), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .enable(enable), .out_valid(out_valid),
    .out_ready(out_ready), .d(d), .out_code(out_code)
`ifdef DECODER_SEQ_SCAN_EN
    , .scan_start(scan_start), .scan_busy(scan_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] hot(input int c);
    logic [OUT_W-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare completing beats first, then record the beat accepted this cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(out_code), 64'hdead);
        end else begin
          chk("sb_beat", 64'({out_code, d}), 64'(sb.pop_front()));
        end
      end
      if (in_valid && in_ready)
        sb.push_back({in_code, (enable ? hot(int'(in_code)) : OUT_W'(0))});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; enable = 1'b1; out_ready = 1'b1;
`ifdef DECODER_SEQ_SCAN_EN
    scan_start = 1'b0;
`endif
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d", 64'(d), 64'd0);
    chk("rst_out_code", 64'(out_code), 64'd0);
`ifdef DECODER_SEQ_SCAN_EN
    chk("rst_scan_busy", 64'(scan_busy), 64'd0);
`endif
    step(); step();
    rst_n = 1'b1;
    step();

    // Single beat, code 5
    in_valid = 1'b1; in_code = 3'd5; enable = 1'b1;
    #1 chk("c5_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("c5_out_valid", 64'(out_valid), 64'd1);
    chk("c5_d", 64'(d), 64'h20);
    chk("c5_out_code", 64'(out_code), 64'd5);
    step();
    chk("c5_drop", 64'(out_valid), 64'd0);

    // Back-to-back stream 0..7
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_code = IN_W'(i);
      #1 chk("stream_in_ready", 64'(in_ready), 64'd1);
      step();
      chk("stream_d", 64'(d), 64'(hot(i)));
      chk("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drop", 64'(out_valid), 64'd0);

    // Backpressure hold on code 3
    in_valid = 1'b1; in_code = 3'd3;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_d", 64'(d), 64'h08);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("release_drop", 64'(out_valid), 64'd0);

    // enable=0 still completes and carries the code
    in_valid = 1'b1; in_code = 3'd6; enable = 1'b0;
    step();
    in_valid = 1'b0; enable = 1'b1;
    chk("en0_d", 64'(d), 64'h00);
    chk("en0_out_code", 64'(out_code), 64'd6);
    chk("en0_valid", 64'(out_valid), 64'd1);
    step();

    // Stall with a waiting beat, then completion and accept in one cycle
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd2;
    step();
    in_code = 3'd4;
    #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("stall_code", 64'(out_code), 64'd2);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("nobubble_code", 64'(out_code), 64'd4);
    chk("nobubble_d", 64'(d), 64'h10);
    step();

`ifdef DECODER_SEQ_SCAN_EN
    // Sweep; scan_start beats a simultaneous in_valid
    scan_start = 1'b1; in_valid = 1'b1; in_code = 3'd1;
    #1 chk("scan_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 8; i++) sb.push_back({IN_W'(i), hot(i)});
    step();
    scan_start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("scan_busy_on", 64'(scan_busy), 64'd1);
      chk("scan_d", 64'(d), 64'(hot(i)));
      chk("scan_code", 64'(out_code), 64'(i));
      scan_start = (i == 3);
      step();
      scan_start = 1'b0;
    end
    chk("scan_busy_off", 64'(scan_busy), 64'd0);
    chk("scan_drop", 64'(out_valid), 64'd0);
    step();

    // Reset in the middle of a sweep, after code 2 completes
    scan_start = 1'b1;
    for (int i = 0; i < 8; i++) sb.push_back({IN_W'(i), hot(i)});
    step();
    scan_start = 1'b0;
    step(); step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("scanrst_valid", 64'(out_valid), 64'd0);
    chk("scanrst_d", 64'(d), 64'd0);
    chk("scanrst_busy", 64'(scan_busy), 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    step();
`endif

    // Asynchronous reset with a held beat
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'd7;
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("holdrst_valid", 64'(out_valid), 64'd0);
    chk("holdrst_d", 64'(d), 64'd0);
    chk("holdrst_code", 64'(out_code), 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b1; in_code = 3'd1;
    step();
    in_valid = 1'b0;
    chk("post_rst_d", 64'(d), 64'h02);
    chk("post_rst_code", 64'(out_code), 64'd1);
    step(); step();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
